// File: rtl/ascon_job_scheduler.sv
// Two-requester job scheduler for a shared ASCON AEAD core: round-robin grant,
// per-job parameter latch, 2-entry block FIFO timed to the core's sample cycles.
module ascon_job_scheduler #(
  parameter int A = 12,
  parameter int B = 6
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [1:0]        req,
  input  logic [1:0][1:0]   req_mode,
  input  logic [1:0][127:0] req_key,
  input  logic [1:0][127:0] req_nonce,
  output logic [1:0]        gnt,
  input  logic [1:0]        blk_valid,
  input  logic [1:0][63:0]  blk_data,
  input  logic [1:0][3:0]   blk_len,
  output logic [1:0]        blk_ready,
  output logic [1:0]        ct_valid,
  output logic [63:0]       ct_data,
  output logic [1:0]        done,
  output logic [127:0]      tag,
  output logic [1:0]        err,
  output logic              core_start,
  output logic [1:0]        core_mode,
  output logic [127:0]      core_key,
  output logic [127:0]      core_nonce,
  output logic [3:0]        core_datalen,
  output logic [63:0]       core_blockin,
  input  logic [63:0]       core_ctblock,
  input  logic              core_ctv,
  input  logic              core_tv,
  input  logic [127:0]      core_tag
);

  localparam int CW = $clog2(A + B + 1);

  typedef enum logic [1:0] {IDLE, START, RUN, FIN} state_t;

  state_t          state;
  logic            rr, pick, own, job_err;
  logic [CW-1:0]   tick;
  logic [1:0]      term_enq, term_smp, term_need;
  logic [1:0][63:0] f_data;
  logic [1:0][3:0]  f_len;
  logic            wp, rp;
  logic [1:0]      f_cnt;
  logic            f_full, f_empty, push, pop, sample, smp_term;
  logic [63:0]     in_data;
  logic [3:0]      in_len;

  always_comb begin
    f_full       = (f_cnt == 2'd2);
    f_empty      = (f_cnt == 2'd0);
    own          = gnt[1];
    pick         = req[rr] ? rr : ~rr;
    term_need    = core_mode[1] ? 2'd2 : 2'd1;
    // Stop accepting once every terminator the job needs is queued.
    blk_ready    = gnt & {2{!f_full && (term_enq < term_need)}};
    push         = |(blk_valid & blk_ready);
    in_data      = blk_data[own];
    in_len       = blk_len[own];
    sample       = (state == RUN) && (tick == '0);
    pop          = sample && !f_empty;
    // An empty FIFO presents a zero-length block, which the core treats as a terminator.
    core_blockin = f_empty ? 64'd0 : f_data[rp];
    core_datalen = f_empty ? 4'd0  : f_len[rp];
    smp_term     = sample && (core_datalen < 4'd8);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      rr         <= 1'b0;
      gnt        <= '0;
      core_start <= 1'b0;
      core_mode  <= '0;
      core_key   <= '0;
      core_nonce <= '0;
      ct_valid   <= '0;
      ct_data    <= '0;
      done       <= '0;
      tag        <= '0;
      err        <= '0;
      job_err    <= 1'b0;
      tick       <= '0;
      term_enq   <= '0;
      term_smp   <= '0;
      f_data     <= '0;
      f_len      <= '0;
      wp         <= 1'b0;
      rp         <= 1'b0;
      f_cnt      <= '0;
    end else begin
      core_start <= 1'b0;
      done       <= '0;
      err        <= '0;
      ct_valid   <= core_ctv ? gnt : 2'b00;
      if (core_ctv) ct_data <= core_ctblock;

      if (push) begin
        f_data[wp] <= in_data;
        f_len[wp]  <= in_len;
        wp         <= ~wp;
        if (in_len < 4'd8) term_enq <= term_enq + 2'd1;
      end
      if (pop) rp <= ~rp;
      f_cnt <= f_cnt + {1'b0, push} - {1'b0, pop};

      case (state)
        IDLE: if (|req) begin
          gnt        <= pick ? 2'b10 : 2'b01;
          rr         <= ~pick;
          core_mode  <= req_mode[pick];
          core_key   <= req_key[pick];
          core_nonce <= req_nonce[pick];
          core_start <= 1'b1;
          job_err    <= 1'b0;
          term_enq   <= '0;
          term_smp   <= '0;
          state      <= START;
        end
        START: begin
          tick  <= CW'(A - 1);
          state <= RUN;
        end
        RUN: if (sample) begin
          tick <= CW'(B - 1);
          if (f_empty) job_err <= 1'b1;
          if (smp_term) begin
            term_smp <= term_smp + 2'd1;
            if (term_smp + 2'd1 == term_need) state <= FIN;
          end
        end else begin
          tick <= tick - 1'b1;
        end
        FIN: if (core_tv) begin
          done  <= gnt;
          tag   <= core_tag;
          err   <= job_err ? gnt : 2'b00;
          gnt   <= '0;
          state <= IDLE;
          wp    <= 1'b0;
          rp    <= 1'b0;
          f_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_job_scheduler.sv
// Scoreboard bench for ascon_job_scheduler: job-level reference model predicts
// grants, block accepts, ct outputs and done/tag/err; a monitor checks them.
module tb_ascon_job_scheduler;
  localparam int A = 12;
  localparam int B = 6;

  logic clk = 1'b0;
  logic nRST;
  logic [1:0] req;
  logic [1:0][1:0] req_mode;
  logic [1:0][127:0] req_key, req_nonce;
  logic [1:0] gnt;
  logic [1:0] blk_valid;
  logic [1:0][63:0] blk_data;
  logic [1:0][3:0] blk_len;
  logic [1:0] blk_ready, ct_valid, done, err;
  logic [63:0] ct_data;
  logic [127:0] tag;
  logic core_start;
  logic [1:0] core_mode;
  logic [127:0] core_key, core_nonce;
  logic [3:0] core_datalen;
  logic [63:0] core_blockin, core_ctblock;
  logic core_ctv, core_tv;
  logic [127:0] core_tag;

  ascon_job_scheduler #(.A(A), .B(B)) dut (
    .clk(clk), .nRST(nRST), .req(req), .req_mode(req_mode), .req_key(req_key),
    .req_nonce(req_nonce), .gnt(gnt), .blk_valid(blk_valid), .blk_data(blk_data),
    .blk_len(blk_len), .blk_ready(blk_ready), .ct_valid(ct_valid), .ct_data(ct_data),
    .done(done), .tag(tag), .err(err), .core_start(core_start), .core_mode(core_mode),
    .core_key(core_key), .core_nonce(core_nonce), .core_datalen(core_datalen),
    .core_blockin(core_blockin), .core_ctblock(core_ctblock), .core_ctv(core_ctv),
    .core_tv(core_tv), .core_tag(core_tag)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] mode; logic [127:0] key, nonce;
    int nb; logic [7:0][63:0] dat; logic [7:0][3:0] len;
    int delay; bit supply;
  } job_t;
  typedef struct { int cyc; int kind; logic [1:0] own; logic [127:0] data; logic [1:0] err; } ev_t;

  job_t jq[2][$];
  ev_t  sb[$];
  int n_cmp = 0, n_fail = 0;
  int m_rr = 0;

  // requester driver and core model state
  bit act[2];
  int bp[2], g[2];
  bit c_run;
  int c_rel, c_terms, c_need, c_T;
  logic [127:0] c_tag;

  function automatic logic [63:0] ctf(input logic [63:0] d, input logic [3:0] l);
    return d ^ {l, 60'h0} ^ 64'h5a5a_0f0f_3c3c_9696;
  endfunction

  function automatic ev_t mk(input int c, input int k, input logic [1:0] o,
                             input logic [127:0] d, input logic [1:0] e);
    ev_t r;
    r.cyc = c; r.kind = k; r.own = o; r.data = d; r.err = e;
    return r;
  endfunction

  function automatic void sb_put(input ev_t e);
    int i = sb.size();
    while (i > 0 && (sb[i-1].cyc * 4 + sb[i-1].kind) > (e.cyc * 4 + e.kind)) i--;
    sb.insert(i, e);
  endfunction

  // One job granted on cycle gc: samples every B after A, done A+1 after the last terminator.
  function automatic int model_job(input job_t j, input int own, input int gc);
    int need = j.mode[1] ? 2 : 1;
    int n = j.supply ? j.nb : need;
    logic [1:0] oh = own ? 2'b10 : 2'b01;
    int d;
    sb_put(mk(gc, 0, oh, '0, '0));
    if (j.supply)
      for (int b = 0; b < j.nb; b++)
        sb_put(mk(b < 2 ? gc + j.delay + b : gc + A + (b - 2) * B + 1, 1, oh, {124'h0, j.len[b]}, '0));
    for (int k = 0; k < n; k++)
      sb_put(mk(gc + A + k * B + 1, 2, oh,
                {64'h0, j.supply ? ctf(j.dat[k], j.len[k]) : ctf(64'h0, 4'h0)}, '0));
    d = gc + 2 * A + (n - 1) * B + 1;
    sb_put(mk(d, 3, oh, j.key ^ j.nonce, j.supply ? 2'b00 : oh));
    return d;
  endfunction

  // Round-robin over the queued jobs; requests become visible on cycle tfree.
  function automatic void model_plan(input int tfree);
    int idx[2];
    int p;
    idx[0] = 0; idx[1] = 0;
    while (idx[0] < jq[0].size() || idx[1] < jq[1].size()) begin
      p = (idx[m_rr] < jq[m_rr].size()) ? m_rr : 1 - m_rr;
      tfree = model_job(jq[p][idx[p]], p, tfree + 1);
      idx[p]++;
      m_rr = 1 - p;
    end
  endfunction

  function automatic job_t mkjob(input logic [1:0] mode, input int nf0, input int l0,
                                 input int nf1, input int l1, input int delay, input bit supply);
    job_t j;
    j.mode = mode; j.delay = delay; j.supply = supply; j.nb = 0;
    j.key = {$urandom, $urandom, $urandom, $urandom};
    j.nonce = {$urandom, $urandom, $urandom, $urandom};
    j.dat = '0; j.len = '0;
    for (int s = 0; s < (mode[1] ? 2 : 1); s++) begin
      for (int f = 0; f < (s == 0 ? nf0 : nf1); f++) begin
        j.dat[j.nb] = {$urandom, $urandom}; j.len[j.nb] = 4'd8; j.nb++;
      end
      j.dat[j.nb] = {$urandom, $urandom}; j.len[j.nb] = 4'(s == 0 ? l0 : l1); j.nb++;
    end
    return j;
  endfunction

  task automatic check(input ev_t got, input string nm);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got unexpected event cyc=%0d own=%b data=%h err=%b, required none",
               nm, got.cyc, got.own, got.data, got.err);
    end else begin
      e = sb.pop_front();
      if (got.cyc !== e.cyc || got.kind !== e.kind || got.own !== e.own ||
          got.data !== e.data || got.err !== e.err) begin
        n_fail++;
        $display("FAIL %s: got cyc=%0d kind=%0d own=%b data=%h err=%b, required cyc=%0d kind=%0d own=%b data=%h err=%b",
                 nm, got.cyc, got.kind, got.own, got.data, got.err, e.cyc, e.kind, e.own, e.data, e.err);
      end
    end
  endtask

  // monitor
  initial forever begin
    @(negedge clk);
    if (nRST === 1'b1) begin
      if (core_start) check(mk(cyc, 0, gnt, '0, '0), "start");
      for (int i = 0; i < 2; i++)
        if (blk_valid[i] && blk_ready[i])
          check(mk(cyc, 1, i ? 2'b10 : 2'b01, {124'h0, blk_len[i]}, '0), "accept");
      if (|ct_valid) check(mk(cyc, 2, ct_valid, {64'h0, ct_data}, '0), "ct");
      if (|done) check(mk(cyc, 3, done, tag, err), "done");
    end
  end

  task automatic check_zero(input string nm);
    logic [649:0] o;
    o = {gnt, blk_ready, ct_valid, ct_data, done, tag, err, core_start, core_mode,
         core_key, core_nonce, core_datalen, core_blockin};
    n_cmp++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL %s: got outputs gnt=%b rdy=%b ctv=%b done=%b err=%b start=%b len=%h, required all zero",
               nm, gnt, blk_ready, ct_valid, done, err, core_start, core_datalen);
    end
  endtask

  // One cycle of requester behaviour plus the core model; ends at posedge+1.
  task automatic step();
    logic [1:0] hs;
    @(negedge clk);
    hs = blk_valid & blk_ready;
    @(posedge clk); #1;
    core_ctv = 1'b0; core_tv = 1'b0;
    if (!nRST) begin
      act[0] = 0; act[1] = 0; bp[0] = 0; bp[1] = 0; c_run = 0;
      req = '0; blk_valid = '0;
      return;
    end
    if (core_start) begin
      c_run = 1; c_rel = 0; c_terms = 0; c_need = core_mode[1] ? 2 : 1;
      c_tag = core_key ^ core_nonce;
    end else if (c_run) c_rel++;
    if (c_run && c_terms < c_need && c_rel >= A && (c_rel - A) % B == 0) begin
      core_ctv = 1'b1;
      core_ctblock = ctf(core_blockin, core_datalen);
      if (core_datalen < 4'd8) begin
        c_terms++;
        if (c_terms == c_need) c_T = c_rel;
      end
    end else if (c_run && c_terms == c_need && c_rel == c_T + A) begin
      core_tv = 1'b1; core_tag = c_tag; c_run = 0;
    end
    for (int i = 0; i < 2; i++) begin
      if (hs[i]) bp[i]++;
      if (done[i] && jq[i].size() > 0) begin
        void'(jq[i].pop_front()); act[i] = 0; bp[i] = 0;
      end
      if (gnt[i] && !act[i] && jq[i].size() > 0) begin
        act[i] = 1; g[i] = cyc; bp[i] = 0;
      end
      req[i] = jq[i].size() > 0;
      if (req[i]) begin
        req_mode[i] = jq[i][0].mode; req_key[i] = jq[i][0].key; req_nonce[i] = jq[i][0].nonce;
      end
      blk_valid[i] = 1'b0;
      if (act[i] && jq[i].size() > 0 && jq[i][0].supply && cyc >= g[i] + jq[i][0].delay) begin
        blk_valid[i] = 1'b1;
        if (bp[i] < jq[i][0].nb) begin
          blk_data[i] = jq[i][0].dat[bp[i]]; blk_len[i] = jq[i][0].len[bp[i]];
        end else begin
          blk_data[i] = 64'hdead_beef_0bad_f00d; blk_len[i] = 4'd8;
        end
      end
    end
  endtask

  task automatic run_plan(input string nm);
    int budget = 0;
    model_plan(cyc + 1);
    while ((jq[0].size() > 0 || jq[1].size() > 0 || sb.size() > 0) && budget < 3000) begin
      step();
      budget++;
    end
    n_cmp++;
    if (budget >= 3000) begin
      n_fail++;
      $display("FAIL %s: got %0d events still pending after %0d cycles, required 0", nm, sb.size(), budget);
      sb.delete(); jq[0].delete(); jq[1].delete();
    end
  endtask

  initial begin
    int g0;
    nRST = 1'b0; req = '0; req_mode = '0; req_key = '0; req_nonce = '0;
    blk_valid = '0; blk_data = '0; blk_len = '0;
    core_ctblock = '0; core_ctv = 1'b0; core_tv = 1'b0; core_tag = '0;
    repeat (3) step();
    check_zero("reset_state");
    nRST = 1'b1;
    step();

    // both requesters at once: grants alternate 0,1,0,1
    jq[0].push_back(mkjob(2'd0, 1, 3, 0, 0, 0, 1));
    jq[0].push_back(mkjob(2'd2, 0, 4, 1, 6, 2, 1));
    jq[1].push_back(mkjob(2'd1, 2, 7, 0, 0, 1, 1));
    jq[1].push_back(mkjob(2'd3, 1, 0, 0, 2, 0, 1));
    run_plan("rr_both");

    jq[0].push_back(mkjob(2'd0, 1, 3, 0, 0, 0, 1));
    run_plan("mode0_basic");
    jq[0].push_back(mkjob(2'd2, 1, 5, 0, 0, 0, 1));
    run_plan("mode2_ad");
    jq[1].push_back(mkjob(2'd1, 0, 0, 0, 0, 0, 0));
    run_plan("underrun");
    jq[1].push_back(mkjob(2'd3, 0, 0, 0, 0, 0, 0));
    run_plan("underrun_ad");
    jq[0].push_back(mkjob(2'd0, 3, 2, 0, 0, 0, 1));
    run_plan("fifo_full");

    for (int s = 0; s < 12; s++) begin
      int nj[2];
      nj[0] = $urandom_range(0, 2); nj[1] = $urandom_range(0, 2);
      if (nj[0] + nj[1] == 0) nj[0] = 1;
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < nj[i]; k++)
          jq[i].push_back(mkjob(2'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, 7),
                                $urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, A - 3),
                                $urandom_range(0, 9) != 0));
      run_plan("random");
    end

    // reset on cycle 15 of a job
    jq[0].push_back(mkjob(2'd0, 3, 3, 0, 0, 0, 1));
    g0 = cyc + 2;
    model_plan(cyc + 1);
    while (cyc < g0 + 15) step();
    nRST = 1'b0;
    sb.delete(); jq[0].delete(); jq[1].delete(); m_rr = 0;
    #1;
    check_zero("mid_job_reset");
    repeat (2) step();
    nRST = 1'b1;
    step();
    jq[1].push_back(mkjob(2'd2, 1, 1, 1, 4, 3, 1));
    jq[0].push_back(mkjob(2'd1, 0, 6, 0, 0, 0, 1));
    run_plan("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
